// File: rtl/serial_capture_pkg.sv
// -----------------------------------------------------------------------------
// serial_capture_pkg
// Shared types and constants for the serial capture unit:
//   order_e       - bit order of an assembled word (LSB first / MSB first)
//   WORD_COUNT_W  - width of the accepted-word counter
//   calc_edges()  - sample events per word; returns 0 for an illegal
//                   width/lane combination so the top can reject it when it
//                   is elaborated
// -----------------------------------------------------------------------------
package serial_capture_pkg;

    typedef enum logic {
        ORDER_LSB = 1'b0,
        ORDER_MSB = 1'b1
    } order_e;

    localparam int WORD_COUNT_W = 16;

    // Number of serial-clock edges needed to fill one word (0 = illegal config).
    function automatic int calc_edges(input int word_w, input int lanes);
        int edges;
        if ((lanes > 0) && (word_w > 0) && ((word_w % lanes) == 0)) begin
            edges = word_w / lanes;
        end else begin
            edges = 0;
        end
        return edges;
    endfunction

endpackage

// File: rtl/capture_fifo.sv
// -----------------------------------------------------------------------------
// capture_fifo
// Generic synchronous first-word-fall-through FIFO.
// Ports:
//   clock, resetb        - clock, asynchronous active-low reset
//   push, push_data      - write request and word
//   pop                  - read request (ignored while empty)
//   head_data            - word at the head of the queue
//   full, empty, level   - occupancy status
//   accepted             - the push in this cycle is being written
// A push while full is still accepted when a pop happens in the same cycle:
// the slot being freed at the head is the slot the tail writes into.
// -----------------------------------------------------------------------------
module capture_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     resetb,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     accepted
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic             pop_s;
    logic             push_s;

    assign empty     = (level_r == LVL_W'(0));
    assign full      = (level_r == LVL_W'(DEPTH));
    assign pop_s     = pop & ~empty;
    assign push_s    = push & (~full | pop_s);
    assign accepted  = push_s;
    assign level     = level_r;
    assign head_data = mem_r[rd_ptr_r];

    // Storage array; cleared on reset so the head word reads 0 while empty.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/serial_capture_unit.sv
// -----------------------------------------------------------------------------
// serial_capture_unit
// Oversamples an external serial clock and 1/2/4 data lanes, assembles words
// of WORD_W bits in either bit order and queues them in a FWFT FIFO with a
// valid/ready output stream and sticky overflow reporting.
// Ports:
//   clock, resetb          - system clock, asynchronous active-low reset
//   sclk_i, cs_n_i         - external serial clock / frame select (async)
//   sdata_i                - serial data lanes (lane DATA_LANES-1 most significant)
//   msb_first_i            - bit order, sampled at the first edge of each word
//   out_valid_o/out_data_o - FIFO head, out_ready_i accepts it
//   overflow_o             - sticky drop flag, cleared by clear_overflow_i
//   fifo_level_o           - words held
//   word_count_o           - words accepted into the FIFO (wraps)
// Optional build macro: SERIAL_CAPTURE_CSB_EN - when defined, a high cs_n
// holds the unit idle and realigns word boundaries; otherwise cs_n_i is
// ignored and only reset sets word alignment.
// -----------------------------------------------------------------------------
module serial_capture_unit
    import serial_capture_pkg::*;
#(
    parameter int DATA_LANES  = 1,
    parameter int WORD_W      = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clock,
    input  logic                          resetb,
    input  logic                          sclk_i,
    input  logic                          cs_n_i,
    input  logic [DATA_LANES-1:0]         sdata_i,
    input  logic                          msb_first_i,
    output logic                          out_valid_o,
    output logic [WORD_W-1:0]             out_data_o,
    input  logic                          out_ready_i,
    output logic                          overflow_o,
    input  logic                          clear_overflow_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic [WORD_COUNT_W-1:0]       word_count_o
);

    localparam int EDGES = calc_edges(WORD_W, DATA_LANES);
    localparam int CNT_W = (EDGES > 1) ? $clog2(EDGES) : 1;
    localparam int LAST  = SYNC_STAGES - 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(EDGES - 1);

    if (EDGES == 0) begin : g_bad_width
        $error("serial_capture_unit: WORD_W must be a multiple of DATA_LANES");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("serial_capture_unit: SYNC_STAGES must be at least 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("serial_capture_unit: FIFO_DEPTH must be a power of two >= 2");
    end

    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] cs_sync_r;
    logic [DATA_LANES-1:0]  data_sync_r [SYNC_STAGES];
    logic                   sclk_prev_r;
    logic                   sample_s;
    logic                   cs_high_s;

    logic [CNT_W-1:0]       cnt_r,   cnt_next_s;
    logic [WORD_W-1:0]      shift_r, shift_next_s;
    order_e                 order_r, order_next_s, cur_order_s;
    logic                   push_r,  push_next_s;
    logic [WORD_W-1:0]      lane_word_s;

    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic                   fifo_accept_s;
    logic                   drop_s;
    logic                   overflow_r;
    logic [WORD_COUNT_W-1:0] count_r;

    // Identical synchroniser chains keep clock, select and data aligned.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            sclk_sync_r <= {SYNC_STAGES{1'b0}};
            cs_sync_r   <= {SYNC_STAGES{1'b0}};
            sclk_prev_r <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                data_sync_r[i] <= {DATA_LANES{1'b0}};
            end
        end else begin
            sclk_sync_r    <= {sclk_sync_r[SYNC_STAGES-2:0], sclk_i};
            cs_sync_r      <= {cs_sync_r[SYNC_STAGES-2:0], cs_n_i};
            sclk_prev_r    <= sclk_sync_r[LAST];
            data_sync_r[0] <= sdata_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                data_sync_r[i] <= data_sync_r[i-1];
            end
        end
    end

    assign sample_s = sclk_sync_r[LAST] & ~sclk_prev_r;

`ifdef SERIAL_CAPTURE_CSB_EN
    assign cs_high_s = cs_sync_r[LAST];
`else
    logic unused_cs_s;
    assign unused_cs_s = ^cs_sync_r;
    assign cs_high_s   = 1'b0;
`endif

    // Word assembly: bit order is taken at the first edge of a word and held.
    always_comb begin
        cnt_next_s   = cnt_r;
        shift_next_s = shift_r;
        order_next_s = order_r;
        push_next_s  = 1'b0;
        lane_word_s  = WORD_W'(data_sync_r[LAST]);
        cur_order_s  = (cnt_r == {CNT_W{1'b0}}) ? order_e'(msb_first_i) : order_r;
        if (cs_high_s) begin
            // Deselected: drop any partial word; stale shift bits are shifted out by the next word.
            cnt_next_s = {CNT_W{1'b0}};
        end else if (sample_s) begin
            order_next_s = cur_order_s;
            if (cur_order_s == ORDER_MSB) begin
                shift_next_s = (shift_r << DATA_LANES) | lane_word_s;
            end else begin
                shift_next_s = (shift_r >> DATA_LANES) | (lane_word_s << (WORD_W - DATA_LANES));
            end
            if (cnt_r == LAST_CNT) begin
                cnt_next_s  = {CNT_W{1'b0}};
                push_next_s = 1'b1;
            end else begin
                cnt_next_s  = cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Assembly state; push_r qualifies shift_r as a complete word one cycle later.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            cnt_r   <= {CNT_W{1'b0}};
            shift_r <= {WORD_W{1'b0}};
            order_r <= ORDER_LSB;
            push_r  <= 1'b0;
        end else begin
            cnt_r   <= cnt_next_s;
            shift_r <= shift_next_s;
            order_r <= order_next_s;
            push_r  <= push_next_s;
        end
    end

    capture_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .resetb    (resetb),
        .push      (push_r),
        .push_data (shift_r),
        .pop       (out_ready_i),
        .head_data (out_data_o),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .level     (fifo_level_o),
        .accepted  (fifo_accept_s)
    );

    assign out_valid_o = ~fifo_empty_s;
    assign drop_s      = push_r & fifo_full_s & ~fifo_accept_s;

    // Sticky overflow (a new drop beats a clear) and accepted-word counter.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            overflow_r <= 1'b0;
            count_r    <= {WORD_COUNT_W{1'b0}};
        end else begin
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (clear_overflow_i) begin
                overflow_r <= 1'b0;
            end
            if (fifo_accept_s) begin
                count_r <= count_r + WORD_COUNT_W'(1);
            end
        end
    end

    assign overflow_o   = overflow_r;
    assign word_count_o = count_r;

endmodule

// File: tb/tb_serial_capture_unit.sv
// -----------------------------------------------------------------------------
// tb_serial_capture_unit
// Directed bench: one single-lane instance with a 4-deep FIFO and one 4-lane
// instance. Expected words are queued when a word is sent and compared when
// the DUT hands them out.
// -----------------------------------------------------------------------------
module tb_serial_capture_unit;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        resetb;
    logic        cs_n;
    // single-lane instance
    logic        sclk1, msb1, ready1, clr1;
    logic [0:0]  sdata1;
    logic        valid1, ovf1;
    logic [7:0]  data1;
    logic [2:0]  level1;
    logic [15:0] count1;
    // four-lane instance
    logic        sclk4, msb4;
    logic [3:0]  sdata4;
    logic        valid4, ovf4;
    logic [7:0]  data4;
    logic [4:0]  level4;
    logic [15:0] count4;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp4_q[$];

    serial_capture_unit #(.DATA_LANES(1), .WORD_W(8), .FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
        .clock(clock), .resetb(resetb), .sclk_i(sclk1), .cs_n_i(cs_n), .sdata_i(sdata1),
        .msb_first_i(msb1), .out_valid_o(valid1), .out_data_o(data1), .out_ready_i(ready1),
        .overflow_o(ovf1), .clear_overflow_i(clr1), .fifo_level_o(level1), .word_count_o(count1)
    );

    serial_capture_unit #(.DATA_LANES(4), .WORD_W(8), .FIFO_DEPTH(16), .SYNC_STAGES(2)) dut4 (
        .clock(clock), .resetb(resetb), .sclk_i(sclk4), .cs_n_i(1'b0), .sdata_i(sdata4),
        .msb_first_i(msb4), .out_valid_o(valid4), .out_data_o(data4), .out_ready_i(1'b1),
        .overflow_o(ovf4), .clear_overflow_i(1'b0), .fifo_level_o(level4), .word_count_o(count4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard for the single-lane instance.
    always @(negedge clock) begin
        if (resetb && valid1 && ready1) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL out1_unexpected: observed word %0h expected no word", data1);
            end
            if (exp_q.size() > 0) check("out1_data", data1, exp_q.pop_front());
        end
    end

    // Scoreboard for the four-lane instance.
    always @(negedge clock) begin
        if (resetb && valid4) begin
            checks++;
            assert (exp4_q.size() > 0) else begin
                errors++;
                $error("FAIL out4_unexpected: observed word %0h expected no word", data4);
            end
            if (exp4_q.size() > 0) check("out4_data", data4, exp4_q.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    // One serial bit: data set while sclk is low, then a 3-cycle high phase.
    task automatic bit1(input logic b);
        @(negedge clock);
        sdata1 = b;
        repeat (3) @(negedge clock);
        sclk1 = 1'b1;
        repeat (3) @(negedge clock);
        sclk1 = 1'b0;
    endtask

    task automatic send_word1(input logic [7:0] w, input logic msb, input logic expect_push);
        msb1 = msb;
        if (expect_push) exp_q.push_back(w);
        for (int i = 0; i < 8; i++) bit1(msb ? w[7-i] : w[i]);
    endtask

    task automatic nib4(input logic [3:0] n);
        @(negedge clock);
        sdata4 = n;
        repeat (3) @(negedge clock);
        sclk4 = 1'b1;
        repeat (3) @(negedge clock);
        sclk4 = 1'b0;
    endtask

    task automatic send_byte4(input logic [7:0] w, input logic msb);
        msb4 = msb;
        exp4_q.push_back(w);
        if (msb) begin
            nib4(w[7:4]);
            nib4(w[3:0]);
        end else begin
            nib4(w[3:0]);
            nib4(w[7:4]);
        end
    endtask

    task automatic drain_all();
        for (int i = 0; i < 100 && (exp_q.size() != 0 || exp4_q.size() != 0); i++) @(negedge clock);
        check("drain1_left", exp_q.size(), 0);
        check("drain4_left", exp4_q.size(), 0);
    endtask

    task automatic reset_all();
        @(negedge clock);
        resetb = 1'b0;
        @(negedge clock);
        check("rst_valid1", valid1, 1'b0);
        check("rst_data1",  data1,  8'h00);
        check("rst_ovf1",   ovf1,   1'b0);
        check("rst_level1", level1, 3'd0);
        check("rst_count1", count1, 16'd0);
        check("rst_valid4", valid4, 1'b0);
        check("rst_count4", count4, 16'd0);
        @(negedge clock);
        resetb = 1'b1;
    endtask

    initial begin
        resetb = 1'b0; cs_n = 1'b0;
        sclk1 = 1'b0; sdata1 = 1'b0; msb1 = 1'b1; ready1 = 1'b1; clr1 = 1'b0;
        sclk4 = 1'b0; sdata4 = 4'h0; msb4 = 1'b1;
        repeat (3) @(negedge clock);
        check("init_valid1", valid1, 1'b0);
        check("init_level1", level1, 3'd0);
        check("init_count1", count1, 16'd0);
        check("init_ovf1",   ovf1,   1'b0);
        resetb = 1'b1;

        // MSB first 0x48 with exact output latency after the last edge.
        msb1 = 1'b1;
        exp_q.push_back(8'h48);
        for (int i = 0; i < 7; i++) bit1((i == 1 || i == 4) ? 1'b1 : 1'b0);
        @(negedge clock);
        sdata1 = 1'b0;
        repeat (3) @(negedge clock);
        sclk1 = 1'b1;
        repeat (3) @(negedge clock);
        check("lat_valid_early", valid1, 1'b0);
        @(negedge clock);
        check("lat_valid_on", valid1, 1'b1);
        check("lat_data", data1, 8'h48);
        sclk1 = 1'b0;
        repeat (2) @(negedge clock);
        check("t1_count", count1, 16'd1);
        check("t1_level", level1, 3'd0);

        // LSB first 0x48; msb_first toggled mid-word must not matter.
        msb1 = 1'b0;
        exp_q.push_back(8'h48);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) msb1 = 1'b1;
            bit1((i == 3 || i == 6) ? 1'b1 : 1'b0);
        end
        send_word1(8'h3C, 1'b1, 1'b1);
        drain_all();
        check("t2_count", count1, 16'd3);

        // Four lanes: 0xA,0x5 MSB first and 0x3,0xC LSB first.
        send_byte4(8'hA5, 1'b1);
        send_byte4(8'hC3, 1'b0);
        drain_all();
        check("t3_count4", count4, 16'd2);

        // Overflow with a 4-deep FIFO and no consumer.
        reset_all();
        @(posedge clock); #1 ready1 = 1'b0;
        send_word1(8'h11, 1'b1, 1'b1);
        send_word1(8'h22, 1'b1, 1'b1);
        send_word1(8'h33, 1'b1, 1'b1);
        send_word1(8'h44, 1'b1, 1'b1);
        send_word1(8'h55, 1'b1, 1'b0);
        repeat (3) @(negedge clock);
        check("ovf_level", level1, 3'd4);
        check("ovf_flag",  ovf1,   1'b1);
        check("ovf_count", count1, 16'd4);
        // Sixth word lands in the cycle the head is popped.
        msb1 = 1'b1;
        exp_q.push_back(8'h66);
        for (int i = 0; i < 7; i++) bit1((i == 1 || i == 2 || i == 5 || i == 6) ? 1'b1 : 1'b0);
        @(negedge clock);
        sdata1 = 1'b0;
        repeat (3) @(negedge clock);
        sclk1 = 1'b1;
        repeat (3) @(posedge clock);
        #1 ready1 = 1'b1;
        @(posedge clock);
        #1 ready1 = 1'b0;
        @(negedge clock);
        check("popfull_level", level1, 3'd4);
        check("popfull_count", count1, 16'd5);
        check("popfull_ovf",   ovf1,   1'b1);
        repeat (2) @(negedge clock);
        sclk1 = 1'b0;
        @(negedge clock);
        clr1 = 1'b1;
        @(negedge clock);
        clr1 = 1'b0;
        check("ovf_cleared", ovf1, 1'b0);
        @(posedge clock); #1 ready1 = 1'b1;
        drain_all();
        check("ovf_drained_level", level1, 3'd0);

        // Frame select: 3 stray bits, deselect, then 0x55.
        reset_all();
`ifdef SERIAL_CAPTURE_CSB_EN
        exp_q.push_back(8'h55);
`else
        exp_q.push_back(8'hEA);
`endif
        msb1 = 1'b1;
        for (int i = 0; i < 3; i++) bit1(1'b1);
        @(negedge clock);
        cs_n = 1'b1;
        repeat (6) @(negedge clock);
        cs_n = 1'b0;
        repeat (6) @(negedge clock);
        for (int i = 0; i < 8; i++) bit1((i % 2 == 1) ? 1'b1 : 1'b0);
        drain_all();
        check("csb_count", count1, 16'd1);

        // Reset after 5 bits discards the partial word.
        reset_all();
        msb1 = 1'b1;
        for (int i = 0; i < 5; i++) bit1((i % 2 == 0) ? 1'b1 : 1'b0);
        reset_all();
        send_word1(8'h7E, 1'b1, 1'b1);
        drain_all();
        repeat (10) @(negedge clock);
        check("rstmid_count", count1, 16'd1);
        check("rstmid_level", level1, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
